tone_arbiter: RTL
=================

TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 SHALL have parameter GAP_MS, default 20: silent gap in ms inserted after every tone; 0 = no gap.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port ticks_per_milli  input  16  clk cycles per ms minus one.
REQ-005 SHALL have port req  input  4  tone request per requester; index 3 highest priority.
REQ-006 SHALL have port req_freq  input  40  10-bit frequency per requester; requester i uses bits [10i+9:10i].
REQ-007 SHALL have port req_dur  input  40  10-bit duration in ms per requester, same packing.
REQ-008 SHALL have port grant  output  4  one-cycle pulse, one-hot, on acceptance.
REQ-009 SHALL have port done  output  4  one-cycle pulse when granted tone completes normally.
REQ-010 SHALL have port abort  output  4  one-cycle pulse when granted tone is preempted.
REQ-011 SHALL have port freq_out  output  10  frequency to tone player; 0 = silence.
REQ-012 SHALL have port busy  output  1  high in PLAY or GAP.

Function
REQ-013 SHALL implement states IDLE, PLAY, GAP.
REQ-014 SHALL generate a ms strobe when the tick counter equals ticks_per_milli; the counter then returns to 0, giving a period of ticks_per_milli+1 cycles; ticks_per_milli=0 gives a strobe every cycle.
REQ-015 SHALL, in IDLE with any req bit high at an edge, enter PLAY on that edge, pulse grant for the highest set index, and latch that requester's freq and dur.
REQ-016 SHALL drive freq_out with the latched freq throughout PLAY, starting in the grant cycle; zero latency from grant to sound.
REQ-017 SHALL clear the tick and ms counters at grant; PLAY SHALL last exactly dur*(ticks_per_milli+1) cycles; dur=0 SHALL be treated as 1.
REQ-018 SHALL, at PLAY end, drive freq_out to 0 and pulse done for the owner in the same cycle, then enter GAP; with GAP_MS=0 it SHALL enter IDLE instead.
REQ-019 SHALL hold freq_out at 0 for GAP_MS ms in GAP, then enter IDLE; requests SHALL be arbitrated only in IDLE.
REQ-020 SHALL ignore req changes, and changes to req_freq and req_dur, after grant; requester may drop req any time after grant.
REQ-021 SHALL treat req still high at IDLE as a new request, so a held req replays the tone repeatedly.
REQ-022 SHALL sample ticks_per_milli live; a change mid-tone takes effect at the next compare.
REQ-023 SHALL keep grant, done and abort one-hot or zero in every cycle.

Reset
REQ-024 SHALL, on rst low, immediately force state IDLE, freq_out 0, grant/done/abort 0, busy 0, and all counters and latches 0, regardless of clk.
REQ-025 SHALL, on reset mid-tone, issue no done or abort; arbitration SHALL resume on the first edge after rst deasserts.

Configuration
REQ-026 SHALL support macro TONE_ARB_PREEMPT_EN.
REQ-027 With TONE_ARB_PREEMPT_EN defined: in PLAY or GAP, a req with index above the current owner SHALL, on that edge:
  - pulse abort for the owner;
  - pulse grant for the new requester;
  - restart PLAY with the new freq and dur.
REQ-028 Without TONE_ARB_PREEMPT_EN: no preemption; abort SHALL be constant 0.

Verification
REQ-029 ticks_per_milli=9, req=0001, freq0=262, dur0=3, GAP_MS=2 -> grant=0001 next cycle, freq_out=262 for 30 cycles, done=0001 with freq_out=0, busy low 20 cycles later.
REQ-030 req=0101 simultaneously in IDLE -> grant=0100 first; req2 dropped after grant -> grant=0001 after gap.
REQ-031 dur=0, ticks_per_milli=0 -> PLAY lasts exactly 1 cycle, done pulses.
REQ-032 Macro on: req0 playing 196 at ms 1, req3 raised with freq 523 -> abort=0001, grant=1000, freq_out=523 same cycle; macro off: req3 granted only after req0 done plus gap.
REQ-033 rst low in mid-PLAY at freq 330 -> freq_out=0 asynchronously, no done; after rst high, a held req re-granted on the next edge.
REQ-034 GAP_MS=0, req1 held high -> done then grant repeat with exactly one silent IDLE cycle between tones.

Source files
------------

// File: rtl/tone_arbiter.sv
// Four-requester tone arbiter: fixed priority (index 3 highest), PLAY for dur ms, then GAP_MS ms of silence.
// Define TONE_ARB_PREEMPT_EN to let a higher-index request preempt the current owner in PLAY or GAP.
module tone_arbiter #(
    parameter int GAP_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic [3:0]  req,
    input  logic [39:0] req_freq,
    input  logic [39:0] req_dur,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  abort,
    output logic [9:0]  freq_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] GAP_LEN = 16'(GAP_MS);
    localparam logic        GAP_EN  = (GAP_MS != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_tick;
    logic [15:0] r_ms;
    logic [1:0]  r_owner;
    logic [9:0]  r_freq;
    logic [9:0]  r_dur;
    logic [3:0]  r_grant;
    logic [3:0]  r_done;
    logic [3:0]  r_abort;
    logic [9:0]  r_freq_out;
    logic        r_busy;

    logic        w_any;
    logic [1:0]  w_pick;
    logic [9:0]  w_sel_freq;
    logic [9:0]  w_sel_dur;
    logic        w_strobe;
    logic [15:0] w_ms_inc;
    logic        w_play_end;
    logic        w_gap_end;
    logic        w_preempt;
    logic        w_load;
    logic [3:0]  w_grant_nxt;
    logic [3:0]  w_done_nxt;
    logic [3:0]  w_abort_nxt;
    logic [9:0]  w_freq_nxt;
    logic        w_busy_nxt;

    function automatic logic [1:0] f_pick(input logic [3:0] r);
        logic [1:0] idx;
        if (r[3]) begin
            idx = 2'd3;
        end else if (r[2]) begin
            idx = 2'd2;
        end else if (r[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign w_any      = |req;
    assign w_pick     = f_pick(req);
    assign w_strobe   = (r_tick == ticks_per_milli);
    assign w_ms_inc   = r_ms + 16'd1;
    assign w_play_end = (r_state == S_PLAY) && w_strobe && (w_ms_inc == {6'd0, r_dur});
    assign w_gap_end  = (r_state == S_GAP) && w_strobe && (w_ms_inc == GAP_LEN);

`ifdef TONE_ARB_PREEMPT_EN
    assign w_preempt = (r_state != S_IDLE) && w_any && (w_pick > r_owner);
`else
    assign w_preempt = 1'b0;
`endif

    assign w_load = ((r_state == S_IDLE) && w_any) || w_preempt;

    // Select the winning requester's frequency and duration fields
    always_comb begin
        w_sel_freq = 10'd0;
        w_sel_dur  = 10'd0;
        case (w_pick)
            2'd0:    begin w_sel_freq = req_freq[9:0];   w_sel_dur = req_dur[9:0];   end
            2'd1:    begin w_sel_freq = req_freq[19:10]; w_sel_dur = req_dur[19:10]; end
            2'd2:    begin w_sel_freq = req_freq[29:20]; w_sel_dur = req_dur[29:20]; end
            2'd3:    begin w_sel_freq = req_freq[39:30]; w_sel_dur = req_dur[39:30]; end
            default: begin w_sel_freq = 10'd0;           w_sel_dur = 10'd0;          end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; preemption outranks a coincident tone or gap end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PLAY: begin
                if (w_preempt) begin
                    w_state_nxt = S_PLAY;
                end else if (w_play_end) begin
                    w_state_nxt = GAP_EN ? S_GAP : S_IDLE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_GAP: begin
                if (w_preempt) begin
                    w_state_nxt = S_PLAY;
                end else if (w_gap_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the cycle after this edge; sound starts in the grant cycle
    always_comb begin
        w_grant_nxt = 4'd0;
        w_done_nxt  = 4'd0;
        w_abort_nxt = 4'd0;
        w_freq_nxt  = 10'd0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        if (w_load) begin
            w_grant_nxt = f_onehot(w_pick);
            w_freq_nxt  = w_sel_freq;
        end else if (w_state_nxt == S_PLAY) begin
            w_freq_nxt  = r_freq;
        end else begin
            w_freq_nxt  = 10'd0;
        end
        if (w_preempt) begin
            w_abort_nxt = f_onehot(r_owner);
        end else if (w_play_end) begin
            w_done_nxt  = f_onehot(r_owner);
        end else begin
            w_abort_nxt = 4'd0;
            w_done_nxt  = 4'd0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant    <= 4'd0;
            r_done     <= 4'd0;
            r_abort    <= 4'd0;
            r_freq_out <= 10'd0;
            r_busy     <= 1'b0;
        end else begin
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
            r_freq_out <= w_freq_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Tick and ms counters restart at every grant and phase change, idle at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick <= 16'd0;
            r_ms   <= 16'd0;
        end else if (w_load || (r_state == S_IDLE) || w_play_end || w_gap_end) begin
            r_tick <= 16'd0;
            r_ms   <= 16'd0;
        end else if (w_strobe) begin
            r_tick <= 16'd0;
            r_ms   <= w_ms_inc;
        end else begin
            r_tick <= r_tick + 16'd1;
        end
    end

    // Owner and tone parameters latched at acceptance; dur=0 plays as 1 ms
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 2'd0;
            r_freq  <= 10'd0;
            r_dur   <= 10'd0;
        end else if (w_load) begin
            r_owner <= w_pick;
            r_freq  <= w_sel_freq;
            r_dur   <= (w_sel_dur == 10'd0) ? 10'd1 : w_sel_dur;
        end else begin
            r_owner <= r_owner;
            r_freq  <= r_freq;
            r_dur   <= r_dur;
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign abort    = r_abort;
    assign freq_out = r_freq_out;
    assign busy     = r_busy;

endmodule
